// File: rtl/intersection_sequencer.sv
// Two-approach traffic sequencer: NS rests green, EW served on car/ped demand, with ped walk and emergency preemption.
// Latency: phase changes take effect on the clk edge where the internal tick is high; outputs decode state combinationally.
// Backpressure: none; requests are latched or sampled as levels and served when the phase sequence allows.
module intersection_sequencer #(
   parameter int unsigned TICK_DIV  = 6,
   parameter int unsigned GREEN_NS  = 8,
   parameter int unsigned GREEN_EW  = 5,
   parameter int unsigned MIN_GREEN = 3,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned TW        = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_ns,
   input  logic       ped_ew,
   input  logic       car_ew,
   input  logic       emg,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [2:0] phase,
   output logic       tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [CW-1:0] CNT_LAST     = CW'(TICK_DIV - 1);
   localparam logic [TW-1:0] MIN_GREEN_M1 = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] GREEN_NS_M1  = TW'(GREEN_NS - 1);
   localparam logic [TW-1:0] GREEN_EW_M1  = TW'(GREEN_EW - 1);
   localparam logic [TW-1:0] YELLOW_M1    = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] ALLRED_M1    = TW'(ALLRED_T - 1);
   localparam logic [TW-1:0] TIMER_MAX    = '1;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      RED_A = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      RED_B = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ped_ns_l_q, ped_ns_l_d;
   logic          ped_ew_l_q, ped_ew_l_d;
   logic          ew_demand;

   assign tick      = (cnt_q == CNT_LAST);
   assign ew_demand = car_ew | ped_ew_l_q;

   // Prescaler: free-running 0..TICK_DIV-1, wrapping on the tick cycle
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (tick) begin
         cnt_d = '0;
      end
   end

   // Next-state, phase timer and pedestrian latch update
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      ped_ns_l_d = ped_ns_l_q;
      ped_ew_l_d = ped_ew_l_q;

      if (tick) begin
         case (state_q)
            NS_G: begin
               if (emg) begin
                  state_d = NS_Y;
               end else if (ped_ew_l_q && (timer_q >= MIN_GREEN_M1)) begin
                  state_d = NS_Y;
               end else if ((timer_q >= GREEN_NS_M1) && ew_demand) begin
                  state_d = NS_Y;
               end
            end
            EW_G: begin
               if (emg) begin
                  state_d = EW_Y;
               end else if (ped_ns_l_q && (timer_q >= MIN_GREEN_M1)) begin
                  state_d = EW_Y;
               end else if (timer_q == GREEN_EW_M1) begin
                  state_d = EW_Y;
               end
            end
            // Yellow always runs to completion, even under preemption
            NS_Y: begin
               if (timer_q == YELLOW_M1) begin
                  state_d = RED_A;
               end
            end
            EW_Y: begin
               if (timer_q == YELLOW_M1) begin
                  state_d = RED_B;
               end
            end
            // Preemption parks the intersection in all-red; the >= test lets
            // it leave on the first tick after emg drops
            RED_A: begin
               if (!emg && (timer_q >= ALLRED_M1)) begin
                  state_d = EW_G;
               end
            end
            RED_B: begin
               if (!emg && (timer_q >= ALLRED_M1)) begin
                  state_d = NS_G;
               end
            end
            default: state_d = RED_B;
         endcase

         if (state_d != state_q) begin
            timer_d = '0;
         end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TW'(1);
         end

         // Entering a green serves the walk request for that direction
         if ((state_d == NS_G) && (state_q != NS_G)) begin
            ped_ns_l_d = 1'b0;
         end
         if ((state_d == EW_G) && (state_q != EW_G)) begin
            ped_ew_l_d = 1'b0;
         end
      end

      // A request arriving on the serving tick stays pending
      if (ped_ns) begin
         ped_ns_l_d = 1'b1;
      end
      if (ped_ew) begin
         ped_ew_l_d = 1'b1;
      end
   end

   // All state flops, asynchronously reset to the all-red RED_B rest point
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RED_B;
         timer_q    <= '0;
         cnt_q      <= '0;
         ped_ns_l_q <= 1'b0;
         ped_ew_l_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         ped_ns_l_q <= ped_ns_l_d;
         ped_ew_l_q <= ped_ew_l_d;
      end
   end

   // Signal head and walk decode; any unlisted code shows all red
   always_comb begin
      ns_light = RED;
      ew_light = RED;
      walk_ns  = 1'b0;
      walk_ew  = 1'b0;
      case (state_q)
         NS_G: begin
            ns_light = GRN;
            walk_ns  = 1'b1;
         end
         NS_Y: ns_light = YEL;
         EW_G: begin
            ew_light = GRN;
            walk_ew  = 1'b1;
         end
         EW_Y: ew_light = YEL;
         default: begin
            ns_light = RED;
            ew_light = RED;
         end
      endcase
   end

   assign phase = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed bench for intersection_sequencer with default parameters.
// Samples on the falling edge; one tick = 6 clks.
// Checks phase, heads and walk outputs at every step plus the safety invariant every cycle.
module tb_intersection_sequencer;

   localparam int TD = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       ped_ns, ped_ew, car_ew, emg;
   logic [2:0] ns_light, ew_light, phase;
   logic       walk_ns, walk_ew, tick;

   int total = 0;
   int bad   = 0;

   logic [2:0] seq [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
   int         dur [6] = '{3, 1, 5, 3, 1, 8};

   intersection_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .ped_ns   (ped_ns),
      .ped_ew   (ped_ew),
      .car_ew   (car_ew),
      .emg      (emg),
      .ns_light (ns_light),
      .ew_light (ew_light),
      .walk_ns  (walk_ns),
      .walk_ew  (walk_ew),
      .phase    (phase),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   // Expected {ns_light, ew_light, walk_ns, walk_ew} for a phase code
   function automatic logic [7:0] exp_out(input logic [2:0] p);
      case (p)
         3'd0:    exp_out = {3'b001, 3'b100, 1'b1, 1'b0};
         3'd1:    exp_out = {3'b010, 3'b100, 1'b0, 1'b0};
         3'd3:    exp_out = {3'b100, 3'b001, 1'b0, 1'b1};
         3'd4:    exp_out = {3'b100, 3'b010, 1'b0, 1'b0};
         default: exp_out = {3'b100, 3'b100, 1'b0, 1'b0};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [2:0] p);
      chk({tag, ".phase"}, {5'b0, phase}, {5'b0, p});
      chk({tag, ".out"}, {ns_light, ew_light, walk_ns, walk_ew}, exp_out(p));
   endtask

   // Advance n clocks, sampling on each falling edge and checking the safety invariant
   task automatic adv_clks(input int n);
      repeat (n) begin
         @(negedge clk);
         total++;
         assert (!((ns_light !== 3'b100) && (ew_light !== 3'b100))) else begin
            bad++;
            $error("FAIL safety observed ns=%b ew=%b expected one head red", ns_light, ew_light);
         end
      end
   endtask

   task automatic adv_ticks(input int n);
      adv_clks(n * TD);
   endtask

   initial begin
      rst = 1'b1; ped_ns = 1'b0; ped_ew = 1'b0; car_ew = 1'b0; emg = 1'b0;

      // ---- 1: reset and NS rest ----
      adv_clks(2);
      chk_state("rst", 3'd5);
      chk("rst.tick", {7'b0, tick}, 8'h00);
      rst = 1'b0;
      adv_clks(5);
      chk_state("pre_tick", 3'd5);
      chk("first_tick", {7'b0, tick}, 8'h01);
      adv_clks(1);
      chk_state("ns_enter", 3'd0);
      for (int k = 0; k < 5; k++) begin
         adv_ticks(10);
         chk_state("ns_rest", 3'd0);
      end

      // ---- 2: constant car_ew, full cycle twice ----
      car_ew = 1'b1;
      adv_ticks(1);
      chk_state("car.nsy", 3'd1);
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 6; i++) begin
            chk_state("cyc.enter", seq[i]);
            adv_ticks(dur[i] - 1);
            chk_state("cyc.last", seq[i]);
            adv_ticks(1);
         end
      end
      chk_state("cyc.wrap", 3'd1);
      car_ew = 1'b0;
      adv_ticks(13);
      chk_state("back_ns", 3'd0);

      // ---- 3: ped_ew pulse at NS_G timer 0 cuts green to 3 ticks ----
      ped_ew = 1'b1;
      adv_clks(1);
      ped_ew = 1'b0;
      adv_clks(5);
      adv_ticks(1);
      chk_state("ped.ns_t2", 3'd0);
      adv_ticks(1);
      chk_state("ped.nsy", 3'd1);
      adv_ticks(3);
      chk_state("ped.reda", 3'd2);
      adv_ticks(1);
      chk_state("ped.ewg", 3'd3);
      adv_ticks(4);
      chk_state("ped.ewg_last", 3'd3);
      adv_ticks(1);
      chk_state("ped.ewy", 3'd4);
      adv_ticks(4);
      chk_state("ped.ns", 3'd0);
      adv_ticks(12);
      chk_state("ped.cleared", 3'd0);

      // ---- 4: emergency during EW_G ----
      car_ew = 1'b1;
      adv_ticks(1);
      chk_state("emg.nsy", 3'd1);
      car_ew = 1'b0;
      adv_ticks(4);
      chk_state("emg.ewg0", 3'd3);
      adv_ticks(1);
      chk_state("emg.ewg1", 3'd3);
      emg = 1'b1;
      adv_ticks(1);
      chk_state("emg.ewy", 3'd4);
      adv_ticks(2);
      chk_state("emg.ewy_last", 3'd4);
      adv_ticks(1);
      chk_state("emg.redb", 3'd5);
      adv_ticks(10);
      chk_state("emg.hold", 3'd5);
      emg = 1'b0;
      adv_ticks(1);
      chk_state("emg.release", 3'd0);

      // ---- 5: ped_ns on the NS_G entry edge stays pending ----
      car_ew = 1'b1;
      adv_ticks(7);
      chk_state("setw.ns_last", 3'd0);
      adv_ticks(1);
      chk_state("setw.nsy", 3'd1);
      car_ew = 1'b0;
      adv_ticks(4);
      chk_state("setw.ewg", 3'd3);
      adv_ticks(5);
      chk_state("setw.ewy", 3'd4);
      adv_ticks(3);
      chk_state("setw.redb", 3'd5);
      adv_clks(5);
      chk("setw.tick", {7'b0, tick}, 8'h01);
      ped_ns = 1'b1;
      adv_clks(1);
      ped_ns = 1'b0;
      chk_state("setw.nsg", 3'd0);
      car_ew = 1'b1;
      adv_ticks(8);
      chk_state("setw.nsy2", 3'd1);
      car_ew = 1'b0;
      adv_ticks(4);
      chk_state("setw.ewg2", 3'd3);
      adv_ticks(2);
      chk_state("setw.ewg_t2", 3'd3);
      adv_ticks(1);
      chk_state("setw.ew_cut", 3'd4);
      adv_ticks(4);
      chk_state("setw.back_ns", 3'd0);

      // ---- 6: reset in the middle of NS_Y ----
      car_ew = 1'b1;
      adv_ticks(8);
      chk_state("mrst.nsy", 3'd1);
      adv_clks(2);
      rst = 1'b1;
      #1;
      chk_state("mrst.async", 3'd5);
      chk("mrst.tick", {7'b0, tick}, 8'h00);
      car_ew = 1'b0;
      adv_clks(3);
      rst = 1'b0;
      adv_clks(5);
      chk_state("mrst.pre", 3'd5);
      adv_clks(1);
      chk_state("mrst.ns", 3'd0);
      adv_ticks(20);
      chk_state("mrst.rest", 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
